mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have ports cpu_req, cpu_we  input  1 each  CPU access request; 1 = write, 0 = read.
REQ-006 The block SHALL have ports cpu_addr  input  ADDR_W and cpu_wdata  input  DATA_W  CPU address and write data.
REQ-007 The block SHALL have ports io_req, io_we  input  1 each  IO requester access request; 1 = write, 0 = read.
REQ-008 The block SHALL have ports io_addr  input  ADDR_W and io_wdata  input  DATA_W  IO address and write data.
REQ-009 The block SHALL have ports cpu_gnt, io_gnt, cpu_ack, io_ack  output  1 each  grant and completion strobes.
REQ-010 The block SHALL have port rdata  output  DATA_W  read data returned to the acknowledged requester.
REQ-011 The block SHALL have ports mem_read, mem_write  output  1 each, adress  output  ADDR_W, indata  output  DATA_W  memory command side.
REQ-012 The block SHALL have port outdata  input  DATA_W  memory read data, valid the cycle after the edge that samples mem_read.
REQ-013 The block SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, DONE; one transaction takes exactly 3 cycles: IDLE (decision) -> ACCESS -> DONE -> IDLE.
REQ-015 In IDLE, cpu_req and io_req SHALL be sampled; with no request the FSM SHALL stay in IDLE.
REQ-016 With one request, that requester SHALL be granted; with both, the port not granted last (last_gnt pointer) SHALL be granted.
REQ-017 On the grant edge the block SHALL capture the winner's we, addr and wdata into internal registers, set last_gnt to the winner, and enter ACCESS.
REQ-018 Requester inputs SHALL be ignored outside IDLE; captured command values SHALL not change until the next grant.
REQ-019 In ACCESS, adress and indata SHALL equal the captured values, and exactly one of mem_read (we=0) or mem_write (we=1) SHALL be 1.
REQ-020 In IDLE and DONE, mem_read and mem_write SHALL be 0; adress and indata SHALL hold their last captured values.
REQ-021 cpu_gnt or io_gnt SHALL be 1 for the winning port during ACCESS and DONE only; the two SHALL never be 1 together.
REQ-022 In DONE, the winner's ack SHALL be 1 for exactly that one cycle; for reads, rdata SHALL be registered from outdata on the DONE->IDLE edge.
REQ-023 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-024 A requester SHALL deassert req no later than its ack cycle; req still high on return to IDLE SHALL be treated as a new request.
REQ-025 Under continuous contention, grants SHALL alternate CPU, IO, CPU, ... with one grant every 3 cycles, so neither port starves.
REQ-026 A request arriving in ACCESS or DONE SHALL wait; it SHALL be arbitrated in the next IDLE cycle.

Reset
REQ-027 While reset=0, asynchronously: state=IDLE; last_gnt=IO, so the CPU wins the first contention; all gnt, ack, mem_read, mem_write and busy outputs = 0; rdata, adress and indata = 0.
REQ-028 Reset asserted during ACCESS SHALL drop mem_read/mem_write immediately; the in-flight transaction SHALL be discarded with no ack.
REQ-029 After reset release, the first rising edge SHALL perform normal IDLE arbitration.

Verification
REQ-030 CPU read: mem[0x005]=0x1234, cpu_req=1, we=0, addr=0x005 -> mem_read=1 and adress=0x005 in cycle 2, cpu_ack=1 in cycle 3, rdata=0x1234 from cycle 4.
REQ-031 IO write: io_req=1, we=1, addr=0xFFF, wdata=0xBEEF -> mem_write=1, indata=0xBEEF, adress=0xFFF for one cycle; io_ack 1 cycle later; readback gives 0xBEEF.
REQ-032 Simultaneous requests after reset -> CPU granted first, IO second; with both held continuously, grant order C,I,C,I at 3-cycle spacing.
REQ-033 IO request raised during a CPU ACCESS -> io_gnt absent until the CPU DONE has ended; IO enters ACCESS 2 cycles after CPU DONE.
REQ-034 reset=0 in the ACCESS cycle of a write -> mem_write falls without a clock edge, no ack is given, busy=0, state IDLE.
REQ-035 Throughout all tests, assert: cpu_gnt&io_gnt never 1; mem_read&mem_write never 1; each ack lasts 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : two-port (CPU / IO) round-robin arbiter in front of a single-port synchronous memory.
// Latency : 3 cycles per transaction (IDLE decision -> ACCESS -> DONE); read data valid the cycle after DONE.
// Backpr. : no queueing; a request waits in its source until the FSM is back in IDLE, then is arbitrated.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, io_req/we/addr/wdata - requester command inputs
//   cpu_gnt, io_gnt     - winner indication during ACCESS and DONE
//   cpu_ack, io_ack     - one-cycle completion strobe in DONE
//   rdata               - last completed read data (held across writes)
//   mem_read, mem_write, adress, indata - memory command (strobes only in ACCESS)
//   outdata             - memory read data, valid the cycle after mem_read is sampled
//   busy                - high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              cpu_gnt,
  output logic              io_gnt,
  output logic              cpu_ack,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] indata,
  input  logic [DATA_W-1:0] outdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t r_state;

  // Round-robin pointer: 1 means IO won the most recent grant. Resets to IO
  // so that the CPU wins the first contention.
  logic r_last_gnt_io;

  // Captured command of the current winner; held until the next grant.
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Registered outputs.
  logic              r_cpu_gnt;
  logic              r_io_gnt;
  logic              r_cpu_ack;
  logic              r_io_ack;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata;

  // Arbitration decision, only consumed in IDLE.
  logic              w_any_req;
  logic              w_pick_io;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_any_req = cpu_req | io_req;
    // IO wins when it is the only requester, or when both request and the
    // CPU was granted last.
    w_pick_io = io_req & (~cpu_req | ~r_last_gnt_io);
    w_we      = w_pick_io ? io_we    : cpu_we;
    w_addr    = w_pick_io ? io_addr  : cpu_addr;
    w_wdata   = w_pick_io ? io_wdata : cpu_wdata;
  end

  // Single FSM block; every output is a register computed one edge ahead so
  // that it is glitch-free and cleared asynchronously by reset (an in-flight
  // mem_read/mem_write drops the instant reset asserts).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_gnt_io <= 1'b1;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cpu_gnt     <= 1'b0;
      r_io_gnt      <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_io_ack      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_busy        <= 1'b0;
      r_rdata       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state       <= ACCESS;
            r_last_gnt_io <= w_pick_io;
            r_we          <= w_we;
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_cpu_gnt     <= ~w_pick_io;
            r_io_gnt      <= w_pick_io;
            r_mem_read    <= ~w_we;
            r_mem_write   <= w_we;
            r_busy        <= 1'b1;
          end
        end

        ACCESS: begin
          r_state     <= DONE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          // Grant flags still identify the winner here.
          r_cpu_ack   <= r_cpu_gnt;
          r_io_ack    <= r_io_gnt;
        end

        DONE: begin
          r_state   <= IDLE;
          r_cpu_gnt <= 1'b0;
          r_io_gnt  <= 1'b0;
          r_cpu_ack <= 1'b0;
          r_io_ack  <= 1'b0;
          r_busy    <= 1'b0;
          // Memory returns data the cycle after the read strobe was sampled,
          // which is this DONE cycle.
          if (!r_we) begin
            r_rdata <= outdata;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cpu_gnt   <= 1'b0;
          r_io_gnt    <= 1'b0;
          r_cpu_ack   <= 1'b0;
          r_io_ack    <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_gnt   = r_cpu_gnt;
  assign io_gnt    = r_io_gnt;
  assign cpu_ack   = r_cpu_ack;
  assign io_ack    = r_io_ack;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign adress    = r_addr;
  assign indata    = r_wdata;
  assign rdata     = r_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a synchronous memory model.
// Latency : drives at posedge+1, samples at posedge+1 before driving the next cycle.
// Backpr. : none; all stimulus runs for fixed cycle counts.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              io_req = 1'b0, io_we = 1'b0;
  logic [ADDR_W-1:0] io_addr = '0;
  logic [DATA_W-1:0] io_wdata = '0;
  logic              cpu_gnt, io_gnt, cpu_ack, io_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] adress;
  logic [DATA_W-1:0] indata;
  logic [DATA_W-1:0] outdata = '0;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  // Status word: {busy, cpu_gnt, io_gnt, cpu_ack, io_ack, mem_read, mem_write}
  logic [6:0] st;
  assign st = {busy, cpu_gnt, io_gnt, cpu_ack, io_ack, mem_read, mem_write};

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .cpu_gnt(cpu_gnt), .io_gnt(io_gnt), .cpu_ack(cpu_ack), .io_ack(io_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .adress(adress), .indata(indata), .outdata(outdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_read is sampled.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_read)  outdata <= mem[adress];
    if (mem_write) mem[adress] <= indata;
  end

  // Protocol monitor: mutual exclusion of grants/strobes, one-cycle acks.
  logic prev_cpu_ack = 1'b0, prev_io_ack = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      vectors++;
      if ((cpu_gnt & io_gnt) !== 1'b0) begin
        miscompares++;
        $display("FAIL mon_gnt_excl: cpu_gnt=%b io_gnt=%b required not both 1", cpu_gnt, io_gnt);
      end
      vectors++;
      if ((mem_read & mem_write) !== 1'b0) begin
        miscompares++;
        $display("FAIL mon_rw_excl: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
      end
      vectors++;
      if (((cpu_ack & prev_cpu_ack) | (io_ack & prev_io_ack)) !== 1'b0) begin
        miscompares++;
        $display("FAIL mon_ack_len: cpu_ack=%b io_ack=%b held 2 cycles, required 1", cpu_ack, io_ack);
      end
      prev_cpu_ack <= cpu_ack;
      prev_io_ack  <= io_ack;
    end else begin
      prev_cpu_ack <= 1'b0;
      prev_io_ack  <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; io_req = 1'b1;
    step();
    step();
    vectors++;
    if (st !== 7'b0000000) begin
      miscompares++;
      $display("FAIL rst_status: got %b required 0000000", st);
    end
    vectors++;
    if (rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_rdata: got %h required 0000", rdata);
    end
    vectors++;
    if (adress !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_adress: got %h required 000", adress);
    end
    vectors++;
    if (indata !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_indata: got %h required 0000", indata);
    end
    cpu_req = 1'b0; io_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
    step();  // ACCESS
    cpu_req = 1'b0;
    vectors++;
    if (st !== 7'b1100010 || adress !== 12'h005) begin
      miscompares++;
      $display("FAIL cpu_rd_access: status %b adress %h required 1100010 005", st, adress);
    end
    step();  // DONE
    vectors++;
    if (st !== 7'b1101000) begin
      miscompares++;
      $display("FAIL cpu_rd_done: status %b required 1101000", st);
    end
    step();  // IDLE
    vectors++;
    if (st !== 7'b0000000 || rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL cpu_rd_data: status %b rdata %h required 0000000 1234", st, rdata);
    end
  endtask

  task automatic test_io_write();
    io_req = 1'b1; io_we = 1'b1; io_addr = 12'hFFF; io_wdata = 16'hBEEF;
    step();  // ACCESS
    io_req = 1'b0;
    vectors++;
    if (st !== 7'b1010001 || adress !== 12'hFFF || indata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL io_wr_access: status %b adress %h indata %h required 1010001 fff beef", st, adress, indata);
    end
    step();  // DONE
    vectors++;
    if (st !== 7'b1010100 || adress !== 12'hFFF || rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL io_wr_done: status %b adress %h rdata %h required 1010100 fff 1234", st, adress, rdata);
    end
    step();  // IDLE
    vectors++;
    if (st !== 7'b0000000 || rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL io_wr_idle: status %b rdata %h required 0000000 1234", st, rdata);
    end
    // Readback through the IO port.
    io_req = 1'b1; io_we = 1'b0;
    step();
    io_req = 1'b0;
    step();
    step();
    vectors++;
    if (rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL io_wr_readback: rdata %h required beef", rdata);
    end
  endtask

  task automatic test_contention();
    reset_pulse();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 12'h010;
    for (int k = 0; k < 4; k++) begin
      step();  // ACCESS
      vectors++;
      if ((k % 2 == 0) ? (st !== 7'b1100010 || adress !== 12'h005)
                       : (st !== 7'b1010010 || adress !== 12'h010)) begin
        miscompares++;
        $display("FAIL contend_grant_%0d: status %b adress %h required %s", k, st, adress,
                 (k % 2 == 0) ? "1100010 005" : "1010010 010");
      end
      step();  // DONE
      step();  // IDLE
      vectors++;
      if (st !== 7'b0000000 || rdata !== ((k % 2 == 0) ? 16'h1234 : 16'h00A5)) begin
        miscompares++;
        $display("FAIL contend_idle_%0d: status %b rdata %h required 0000000 %h", k, st, rdata,
                 (k % 2 == 0) ? 16'h1234 : 16'h00A5);
      end
    end
    cpu_req = 1'b0; io_req = 1'b0;
    step();
    vectors++;
    if (st !== 7'b0000000) begin
      miscompares++;
      $display("FAIL contend_release: status %b required 0000000", st);
    end
  endtask

  task automatic test_late_request();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
    step();  // CPU ACCESS
    cpu_req = 1'b0;
    io_req = 1'b1; io_we = 1'b0; io_addr = 12'h010;
    step();  // CPU DONE
    vectors++;
    if (st !== 7'b1101000) begin
      miscompares++;
      $display("FAIL late_cpu_done: status %b required 1101000", st);
    end
    step();  // IDLE, IO arbitrated here
    vectors++;
    if (st !== 7'b0000000) begin
      miscompares++;
      $display("FAIL late_idle: status %b required 0000000", st);
    end
    step();  // IO ACCESS
    io_req = 1'b0;
    vectors++;
    if (st !== 7'b1010010 || adress !== 12'h010) begin
      miscompares++;
      $display("FAIL late_io_access: status %b adress %h required 1010010 010", st, adress);
    end
    step();
    step();
  endtask

  task automatic test_reset_in_access();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'h5555;
    step();  // ACCESS
    cpu_req = 1'b0;
    vectors++;
    if (st !== 7'b1100001) begin
      miscompares++;
      $display("FAIL rstacc_access: status %b required 1100001", st);
    end
    reset = 1'b0;
    #2;  // mid-cycle, no clock edge
    vectors++;
    if (st !== 7'b0000000) begin
      miscompares++;
      $display("FAIL rstacc_async: status %b required 0000000", st);
    end
    step();
    step();
    vectors++;
    if (st !== 7'b0000000) begin
      miscompares++;
      $display("FAIL rstacc_no_ack: status %b required 0000000", st);
    end
    reset = 1'b1;
    // First edge after release arbitrates; pointer is back at IO so CPU wins.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 12'h010;
    step();
    cpu_req = 1'b0; io_req = 1'b0;
    vectors++;
    if (st !== 7'b1100010 || adress !== 12'h020) begin
      miscompares++;
      $display("FAIL rstacc_first_arb: status %b adress %h required 1100010 020", st, adress);
    end
    step();
    step();
    vectors++;
    if (rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL rstacc_discarded_write: rdata %h required 0000", rdata);
    end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h030; cpu_wdata = 16'h7777;
    step();  // ACCESS (write)
    cpu_wdata = 16'hDEAD;  // must be ignored outside IDLE
    step();  // DONE
    cpu_we = 1'b0;         // req held: becomes a new read request
    vectors++;
    if (st !== 7'b1101000 || indata !== 16'h7777) begin
      miscompares++;
      $display("FAIL b2b_done: status %b indata %h required 1101000 7777", st, indata);
    end
    step();  // IDLE
    step();  // ACCESS (read)
    cpu_req = 1'b0;
    vectors++;
    if (st !== 7'b1100010 || adress !== 12'h030) begin
      miscompares++;
      $display("FAIL b2b_read_access: status %b adress %h required 1100010 030", st, adress);
    end
    step();
    step();
    vectors++;
    if (rdata !== 16'h7777) begin
      miscompares++;
      $display("FAIL b2b_readback: rdata %h required 7777", rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[12'h005] = 16'h1234;
    mem[12'h010] = 16'h00A5;
    #1;
    test_reset();
    test_cpu_read();
    test_io_write();
    test_contention();
    test_late_request();
    test_reset_in_access();
    test_back_to_back();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1, "timeout");
  end

endmodule
